// File: rtl/linear_dequant_ctrl.sv
// linear_dequant_ctrl: round-robin two-requester job controller feeding a linear dequant datapath.
// Optional DRAIN watchdog enabled by defining LINEAR_DEQUANT_CTRL_WDOG_EN.
module linear_dequant_ctrl #(
  parameter int CNT_W = 16,
  parameter int OST_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job0_req,
  input  logic [31:0]      job0_divisor,
  input  logic [CNT_W-1:0] job0_beats,
  output logic             job0_ack,
  output logic             job0_done,
  input  logic             job1_req,
  input  logic [31:0]      job1_divisor,
  input  logic [CNT_W-1:0] job1_beats,
  output logic             job1_ack,
  output logic             job1_done,
  input  logic             src0_valid,
  input  logic [255:0]     src0_data,
  output logic             src0_ready,
  input  logic             src1_valid,
  input  logic [255:0]     src1_data,
  output logic             src1_ready,
  output logic             dq_enable,
  output logic             dq_src_valid,
  output logic [255:0]     dq_src_data,
  output logic [31:0]      dq_divisor,
  input  logic             dq_dst_valid,
  output logic             busy,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t           state_q;
  logic             grant_q, prio_q, en_q, src_valid_q, err_q;
  logic [1:0]       ack_q, done_q;
  logic [CNT_W-1:0] rem_q;
  logic [OST_W-1:0] ost_q, ost_d;
  logic [255:0]     data_q;
  logic [31:0]      div_q;
  logic             gnt_d, ready, xfer, inc, dec, ost_max, err_set;
`ifdef LINEAR_DEQUANT_CTRL_WDOG_EN
  logic [5:0]       wd_q;
`endif
  always_comb begin
    gnt_d = (job0_req && job1_req) ? prio_q : job1_req;
    ready = (state_q == RUN) && (rem_q != '0);
    src0_ready = ready && !grant_q;
    src1_ready = ready && grant_q;
    xfer = grant_q ? (src1_valid && src1_ready) : (src0_valid && src0_ready);
    inc = src_valid_q;
    dec = dq_dst_valid;
    ost_max = &ost_q;
    // Both saturating ends flag a protocol error instead of wrapping.
    ost_d = (inc && !dec) ? (ost_max ? ost_q : ost_q + OST_W'(1))
          : (dec && !inc) ? ((ost_q == '0) ? ost_q : ost_q - OST_W'(1))
          : ost_q;
    err_set = (inc && !dec && ost_max) || (dec && !inc && (ost_q == '0));
  end
  assign job0_ack     = ack_q[0];
  assign job1_ack     = ack_q[1];
  assign job0_done    = done_q[0];
  assign job1_done    = done_q[1];
  assign dq_enable    = en_q;
  assign busy         = en_q;
  assign dq_src_valid = src_valid_q;
  assign dq_src_data  = data_q;
  assign dq_divisor   = div_q;
  assign err          = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      en_q        <= 1'b0;
      src_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= '0;
      done_q      <= '0;
      rem_q       <= '0;
      ost_q       <= '0;
      data_q      <= '0;
      div_q       <= '0;
`ifdef LINEAR_DEQUANT_CTRL_WDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      ack_q       <= '0;
      done_q      <= '0;
      src_valid_q <= xfer;
      ost_q       <= ost_d;
      if (xfer) data_q <= grant_q ? src1_data : src0_data;
      if (err_set) err_q <= 1'b1;
`ifdef LINEAR_DEQUANT_CTRL_WDOG_EN
      wd_q <= (state_q == DRAIN && !dec) ? wd_q + 6'd1 : '0;
`endif
      case (state_q)
        IDLE: if (job0_req || job1_req) begin
          state_q <= LOAD;
          grant_q <= gnt_d;
          div_q   <= gnt_d ? job1_divisor : job0_divisor;
          rem_q   <= gnt_d ? job1_beats : job0_beats;
          ack_q   <= gnt_d ? 2'b10 : 2'b01;
          en_q    <= 1'b1;
        end
        LOAD: if (rem_q != '0) state_q <= RUN;
        else begin
          state_q <= DONE;
          done_q  <= grant_q ? 2'b10 : 2'b01;
        end
        RUN: if (xfer) begin
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_q <= DRAIN;
        end
        // ost_d lets DONE follow the final result beat by exactly one cycle.
        DRAIN: if (ost_d == '0 && !src_valid_q) begin
          state_q <= DONE;
          done_q  <= grant_q ? 2'b10 : 2'b01;
        end
`ifdef LINEAR_DEQUANT_CTRL_WDOG_EN
        else if (wd_q == 6'd63) begin
          state_q <= DONE;
          done_q  <= grant_q ? 2'b10 : 2'b01;
          err_q   <= 1'b1;
          ost_q   <= '0;
        end
`endif
        DONE: begin
          state_q <= IDLE;
          prio_q  <= !grant_q;
          en_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_linear_dequant_ctrl.sv
// tb_linear_dequant_ctrl: directed scoreboard bench for linear_dequant_ctrl.
module tb_linear_dequant_ctrl;
  logic         clk, rst;
  logic         job0_req, job0_ack, job0_done, job1_req, job1_ack, job1_done;
  logic [31:0]  job0_divisor, job1_divisor, dq_divisor;
  logic [15:0]  job0_beats, job1_beats;
  logic         src0_valid, src0_ready, src1_valid, src1_ready;
  logic [255:0] src0_data, src1_data, dq_src_data;
  logic         dq_enable, dq_src_valid, dq_dst_valid, busy, err;
  logic [255:0] exp_q[$];
  bit           ack_log[$];
  int           checks = 0, errors = 0, src_cnt = 0, done_cnt = 0, cyc = 0;
  int           last_src = 0, last_dst = 0, base;
  logic [31:0]  exp_div = '0, prev_div = '0;
  bit           active = 0, ok, prev = 0, dst_en = 1, lat0 = 0, inj = 0;

  linear_dequant_ctrl dut (
    .clk(clk), .rst(rst),
    .job0_req(job0_req), .job0_divisor(job0_divisor), .job0_beats(job0_beats),
    .job0_ack(job0_ack), .job0_done(job0_done),
    .job1_req(job1_req), .job1_divisor(job1_divisor), .job1_beats(job1_beats),
    .job1_ack(job1_ack), .job1_done(job1_done),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .dq_enable(dq_enable), .dq_src_valid(dq_src_valid), .dq_src_data(dq_src_data),
    .dq_divisor(dq_divisor), .dq_dst_valid(dq_dst_valid), .busy(busy), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      src0_data = rnd256();
      src1_data = rnd256();
    end
  endtask

  task automatic wait_for(input string tag, input int sel, output bit hit);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      hit = (sel == 0) ? job0_done : (sel == 1) ? job1_done : (job0_done || job1_done);
    end
    check(tag, hit, 1);
  endtask

  task automatic wait_src(input string tag, input int n);
    for (int i = 0; i < 300 && src_cnt < n; i++) tick();
    check(tag, src_cnt >= n, 1);
  endtask

  // Datapath model: result beat one cycle after each issued beat (or same cycle when lat0).
  initial begin
    dq_dst_valid = 0;
    forever begin
      @(posedge clk);
      #2;
      dq_dst_valid = !rst && (inj || (dst_en && (lat0 ? dq_src_valid : prev)));
      prev = !rst && dq_src_valid;
    end
  end

  // Scoreboard and protocol monitor.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      active = 0;
      prev_div = dq_divisor;
    end else begin
      if (job0_ack || job1_ack) begin
        check("ack_after_done", active, 0);
        ack_log.push_back(job1_ack);
        active = 1;
        exp_div = job1_ack ? job1_divisor : job0_divisor;
      end
      if (job0_done || job1_done) begin
        active = 0;
        done_cnt++;
      end
      if (dq_divisor !== prev_div) check("div_chg_in_load", job0_ack || job1_ack, 1);
      prev_div = dq_divisor;
      if (dq_src_valid) begin
        src_cnt++;
        last_src = cyc;
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("src_data", dq_src_data, exp_q.pop_front());
        check("divisor", dq_divisor, exp_div);
      end
      if (dq_dst_valid) last_dst = cyc;
      if (src0_valid && src0_ready) exp_q.push_back(src0_data);
      if (src1_valid && src1_ready) exp_q.push_back(src1_data);
    end
  end

  initial begin
    rst = 1; job0_req = 0; job1_req = 0; job0_divisor = '0; job1_divisor = '0;
    job0_beats = '0; job1_beats = '0; src0_valid = 0; src1_valid = 0;
    src0_data = rnd256(); src1_data = rnd256();
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_en", dq_enable, 0);
    check("rst_err", err, 0);
    check("rst_srcv", dq_src_valid, 0);
    check("rst_div", dq_divisor, 0);
    check("rst_ready", src0_ready, 0);
    rst = 0;
    tick();
    // single job, 3 beats
    src_cnt = 0; job0_divisor = 32'h40000000; job0_beats = 3; src0_valid = 1; job0_req = 1;
    tick();
    check("t1_ack0", job0_ack, 1);
    check("t1_ack1", job1_ack, 0);
    check("t1_busy", busy, 1);
    check("t1_div", dq_divisor, 32'h40000000);
    job0_req = 0;
    wait_for("t1_done", 0, ok);
    check("t1_beats", src_cnt, 3);
    check("t1_done_lat", cyc - last_dst, 1);
    src0_valid = 0;
    tick();
    check("t1_done_pulse", job0_done, 0);
    check("t1_idle", busy, 0);
    check("t1_div_hold", dq_divisor, 32'h40000000);
    // zero-beat job
    src_cnt = 0; job1_divisor = 32'h3f800000; job1_beats = 0; src1_valid = 1; job1_req = 1;
    tick();
    check("t2_ack1", job1_ack, 1);
    check("t2_ready_load", src1_ready, 0);
    job1_req = 0;
    tick();
    check("t2_done1", job1_done, 1);
    check("t2_ready_done", src1_ready, 0);
    tick();
    check("t2_idle", busy, 0);
    check("t2_no_beats", src_cnt, 0);
    src1_valid = 0;
    // contention from reset
    rst = 1; tick(); rst = 0; ack_log.delete();
    job0_divisor = 32'h40400000; job1_divisor = 32'h40800000; job0_beats = 2; job1_beats = 2;
    src0_valid = 1; src1_valid = 1; job0_req = 1; job1_req = 1;
    for (int i = 0; i < 4; i++) wait_for("t3_done", 2, ok);
    job0_req = 0; job1_req = 0;
    for (int i = 0; i < 4; i++) check("t3_order", i < ack_log.size() ? ack_log[i] : 1'bx, i % 2);
    src0_valid = 0; src1_valid = 0;
    tick(2);
    check("t3_err", err, 0);
    // simultaneous issue and result
    lat0 = 1; src_cnt = 0; job0_beats = 4; job0_divisor = 32'h41000000; src0_valid = 1; job0_req = 1;
    tick();
    job0_req = 0;
    wait_for("t4_done", 0, ok);
    check("t4_beats", src_cnt, 4);
    check("t4_err", err, 0);
    lat0 = 0; src0_valid = 0;
    tick();
    // unsolicited result in IDLE
    inj = 1; tick(); inj = 0; tick();
    check("t4_unsol_err", err, 1);
    tick(3);
    check("t4_err_sticky", err, 1);
    check("t4_idle", busy, 0);
    rst = 1; #1;
    check("t4_err_clr", err, 0);
    tick(); rst = 0;
    // outstanding overflow
    dst_en = 0; src_cnt = 0; job0_beats = 16; src0_valid = 1; job0_req = 1;
    tick();
    job0_req = 0;
    wait_src("t5_reach15", 15);
    check("t5_no_err_at_max", err, 0);
    tick(3);
    check("t5_ovf_err", err, 1);
    rst = 1; tick(); rst = 0; dst_en = 1; src0_valid = 0;
    tick();
    // reset mid-RUN
    src_cnt = 0; base = done_cnt; job0_beats = 5; src0_valid = 1; job0_req = 1;
    tick();
    job0_req = 0;
    wait_src("t6_two_beats", 2);
    rst = 1; #1;
    check("t6_busy", busy, 0);
    check("t6_en", dq_enable, 0);
    check("t6_srcv", dq_src_valid, 0);
    check("t6_data", dq_src_data, 0);
    check("t6_div", dq_divisor, 0);
    check("t6_ready", src0_ready, 0);
    check("t6_done", job0_done, 0);
    check("t6_err", err, 0);
    src0_valid = 0;
    tick(2); rst = 0; tick(3);
    check("t6_no_done", done_cnt, base);
    src_cnt = 0; job1_beats = 2; job1_divisor = 32'h40a00000; src1_valid = 1; job1_req = 1;
    tick();
    check("t6_ack1", job1_ack, 1);
    job1_req = 0;
    wait_for("t6_done1", 1, ok);
    check("t6_beats", src_cnt, 2);
    check("t6_err_after", err, 0);
    src1_valid = 0;
    tick();
    // results withheld in DRAIN
    dst_en = 0; src_cnt = 0; job0_beats = 2; src0_valid = 1; job0_req = 1;
    tick();
    job0_req = 0;
    wait_src("t7_beats", 2);
    src0_valid = 0;
`ifdef LINEAR_DEQUANT_CTRL_WDOG_EN
    wait_for("t7_wd_done", 0, ok);
    check("t7_wd_lat", cyc - last_src, 64);
    check("t7_wd_err", err, 1);
`else
    base = done_cnt;
    tick(100);
    check("t7_stuck_busy", busy, 1);
    check("t7_no_done", done_cnt, base);
`endif
    rst = 1; tick(); rst = 0; dst_en = 1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/linear_dequant_ctrl.md
LINEAR_DEQUANT_CTRL -- requirements
Module: linear_dequant_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with the ports listed in REQ-003.
REQ-002 Parameters SHALL be:
- CNT_W, default 16: width of the job beat count.
- OST_W, default 4: width of the outstanding-beat counter.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- jobN_req  in  1  requester N (N=0,1) has a job pending.
- jobN_divisor  in  32  IEEE-754 single divisor for the job (sign[31], exp[30:23], man[22:0]).
- jobN_beats  in  CNT_W  number of 8-lane beats in the job.
- jobN_ack  out  1  one-cycle pulse: job accepted.
- jobN_done  out  1  one-cycle pulse: all results of the job returned.
- srcN_valid  in  1  requester N beat valid.
- srcN_data  in  256  requester N beat: 8 packed singles, lane0 in [31:0].
- srcN_ready  out  1  controller accepts a requester N beat.
- dq_enable  out  1  datapath enable.
- dq_src_valid  out  1  beat issued to the dequant datapath.
- dq_src_data  out  256  issued beat.
- dq_divisor  out  32  divisor held for the active job.
- dq_dst_valid  in  1  datapath result beat valid.
- busy  out  1  state is not IDLE.
- err  out  1  sticky protocol error.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-005 IDLE: if any jobN_req is high, go to LOAD and latch grant, divisor and beats from the selected requester.
REQ-006 Arbitration SHALL be two-way round-robin: when both request, grant the requester not served last; after reset the priority pointer favours requester 0.
REQ-007 LOAD SHALL last exactly one cycle:
- pulse jobN_ack for the granted N;
- drive dq_divisor from the latch;
- go to RUN if beats>0, else go to DONE.
REQ-008 dq_divisor SHALL change only in LOAD and SHALL stay constant from LOAD until leaving DONE.
REQ-009 RUN: srcN_ready SHALL equal (granted N) AND (remaining>0); every other srcN_ready SHALL be 0.
REQ-010 Beat issue:
- a transfer occurs on srcN_valid&srcN_ready;
- each transfer decrements remaining;
- each transfer is registered to dq_src_valid/dq_src_data one cycle later (latency 1);
- dq_src_valid SHALL be 0 in every other cycle.
REQ-011 Outstanding counter:
- +1 on dq_src_valid;
- -1 on dq_dst_valid;
- unchanged when both occur in the same cycle.
REQ-012 RUN SHALL go to DRAIN when remaining reaches 0 after a transfer.
REQ-013 DRAIN SHALL go to DONE when outstanding==0 and dq_src_valid==0.
REQ-014 DONE SHALL last one cycle:
- pulse jobN_done;
- point round-robin priority at the other requester;
- go to IDLE; a new grant is possible at the earliest in the following cycle.
REQ-015 dq_enable SHALL be 1 in LOAD, RUN, DRAIN and DONE, and 0 in IDLE.
REQ-016 busy SHALL be 1 whenever the state is not IDLE.
REQ-017 err SHALL be set, and held until reset, on either of:
- dq_dst_valid with outstanding==0 and no simultaneous dq_src_valid (counter saturates at 0);
- outstanding at maximum (2^OST_W-1) with a dq_src_valid and no simultaneous dq_dst_valid (counter saturates).
REQ-018 jobN_req deasserting after ack SHALL have no effect on the active job.
REQ-019 Changes on the non-granted requester's inputs SHALL have no effect on the active job.

Reset
REQ-020 rst high SHALL asynchronously force:
- state IDLE;
- all outputs 0, including dq_divisor, dq_src_data and err;
- counters 0;
- priority pointer to requester 0.
REQ-021 Reset mid-job SHALL abandon the job: no ack or done pulse for it; dq_dst_valid after reset is counted per REQ-017.

Configuration
REQ-022 With LINEAR_DEQUANT_CTRL_WDOG_EN defined, a 6-bit watchdog SHALL run in DRAIN:
- it counts cycles without dq_dst_valid and clears on each dq_dst_valid;
- at 63 it sets err, clears outstanding and goes to DONE.
REQ-023 Without LINEAR_DEQUANT_CTRL_WDOG_EN, no watchdog logic SHALL exist and DRAIN SHALL wait indefinitely.

Verification
REQ-024 Single job: job0_req=1, job0_beats=3, divisor 0x40000000, src0_valid held 1 -> job0_ack one cycle after the request; 3 dq_src_valid pulses; dq_divisor=0x40000000 throughout; job0_done one cycle after the 3rd dq_dst_valid.
REQ-025 Contention: job0_req and job1_req high from reset -> jobs granted in order 0,1,0,1; each done precedes the next ack; dq_divisor changes only in LOAD.
REQ-026 Zero beats: job1_beats=0 -> sequence LOAD, DONE, IDLE; no srcN_ready and no dq_src_valid.
REQ-027 Simultaneous events: dq_src_valid and dq_dst_valid in the same cycle -> outstanding unchanged; an unsolicited dq_dst_valid in IDLE -> err=1 until rst.
REQ-028 Reset mid-RUN: rst asserted after 2 of 5 beats -> all outputs 0 immediately; no done pulse; next job starts cleanly.
REQ-029 Watchdog (macro defined): withhold dq_dst_valid in DRAIN -> err=1 and jobN_done exactly 64 cycles after DRAIN entry; with the macro undefined -> FSM stays in DRAIN.
